// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word fetches on a req/gnt/rvalid bus, buffers
// {pc, instr} pairs in a small FIFO for decode, and handles execute redirects.
module instr_fetch #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR  = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fetch_instr_valid_o,
  output logic [XLEN-1:0] fetch_pc_r_o,
  output logic [XLEN-1:0] fetch_instr_o,
  input  logic            fetch_instr_ready_i,
  output logic            flush_decode_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_WC = (CNT_W + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             flush_q;

  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0] instr_mem [FIFO_DEPTH];

  logic            pop, push, req, grant;
  logic [CNT_W:0]  credit;
  logic [XLEN-1:0] redirect_pc_al;
  logic            unused_pc_lsb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign redirect_pc_al = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_lsb  = ^redirect_pc_i[1:0];

  // Credits cover buffered entries plus every in-flight response, including ones
  // that will be discarded, so a returning word always has a FIFO slot.
  always_comb begin
    pop    = (count_q != '0) & fetch_instr_ready_i;
    credit = {1'b0, count_q} + {1'b0, outst_q} - {{CNT_W{1'b0}}, pop};
    req    = ~redirect_i & (credit < DEPTH_WC);
    grant  = req & imem_gnt_i;
    push   = imem_rvalid_i & (discard_q == '0) & ~redirect_i;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q - CNT_W'(imem_rvalid_i);
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      discard_d  = outst_q - CNT_W'(imem_rvalid_i);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        outst_d    = outst_q + CNT_W'(1) - CNT_W'(imem_rvalid_i);
      end
      if (imem_rvalid_i && discard_q != '0) discard_d = discard_q - CNT_W'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= BOOT_ADDR;
      resp_pc_q  <= BOOT_ADDR;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      flush_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      flush_q    <= redirect_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (!(push && !pop && count_q == DEPTH_C));
  end

  assign imem_req_o          = req & rst_ni;
  assign imem_addr_o         = fetch_pc_q;
  assign fetch_instr_valid_o = (count_q != '0);
  assign fetch_pc_r_o        = pc_mem[rd_ptr_q];
  assign fetch_instr_o       = instr_mem[rd_ptr_q];
  assign flush_decode_o      = flush_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model returns the fetch address as data,
// with a programmable extra response delay.
module tb_instr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid, ready, flush;
  logic [31:0] pc_r, instr;

  int checks   = 0;
  int failures = 0;

  logic        granted;
  logic [31:0] gaddr;
  int          mem_delay;

  typedef struct {
    logic [31:0] addr;
    int          wait_c;
  } rsp_t;
  rsp_t rq[$];

  instr_fetch #(.XLEN(32), .BOOT_ADDR(32'h100), .FIFO_DEPTH(2)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_n),
    .imem_req_o          (imem_req),
    .imem_addr_o         (imem_addr),
    .imem_gnt_i          (imem_gnt),
    .imem_rvalid_i       (imem_rvalid),
    .imem_rdata_i        (imem_rdata),
    .redirect_i          (redirect),
    .redirect_pc_i       (redirect_pc),
    .fetch_instr_valid_o (valid),
    .fetch_pc_r_o        (pc_r),
    .fetch_instr_o       (instr),
    .fetch_instr_ready_i (ready),
    .flush_decode_o      (flush)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    granted <= imem_req & imem_gnt;
    gaddr   <= imem_addr;
  end

  // Responses are released in order; only the head entry's delay counts down.
  always @(negedge clk_i) begin
    if (!rst_n) begin
      rq.delete();
      imem_rvalid = 1'b0;
    end else begin
      if (granted) begin
        rsp_t r;
        r.addr   = gaddr;
        r.wait_c = mem_delay;
        rq.push_back(r);
      end
      imem_rvalid = 1'b0;
      if (rq.size() > 0) begin
        if (rq[0].wait_c == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = rq[0].addr;
          void'(rq.pop_front());
        end else begin
          rq[0].wait_c = rq[0].wait_c - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
    chk({tag, "_pc"}, pc_r, exp_pc);
    chk({tag, "_instr"}, instr, exp_pc);
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; imem_gnt = 1'b1; redirect = 1'b0;
    redirect_pc = '0; mem_delay = 0; imem_rvalid = 1'b0; imem_rdata = '0;

    repeat (2) @(negedge clk_i);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);

    // Boot stream: one instruction per cycle after start-up
    @(negedge clk_i); #3 rst_n = 1'b1; #1;
    chk("boot_req", {31'b0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h100);
    @(negedge clk_i);
    chk("boot_nobypass", {31'b0, valid}, 32'd0);
    chk("boot_addr2", imem_addr, 32'h104);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk_head("stream", 32'h100 + 32'(4 * i));
    end

    // Decode stall: buffer fills, request stops, head held
    ready = 1'b0; #1;
    chk("stall_req0", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk_head("stall_hold", 32'h10C);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    @(negedge clk_i); ready = 1'b1; #1;
    chk("release_req", {31'b0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'h114);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk_head("release", 32'h110 + 32'(4 * i));
    end

    // Grant withheld, then slow responses
    imem_gnt = 1'b0; #2 mem_delay = 3;
    @(negedge clk_i); chk_head("gnt_drain", 32'h11C); chk("gnt_hold1", imem_addr, 32'h120);
    @(negedge clk_i); chk("gnt_empty", {31'b0, valid}, 32'd0); chk("gnt_hold2", imem_addr, 32'h120);
    @(negedge clk_i); chk("gnt_hold3", imem_addr, 32'h120); imem_gnt = 1'b1;
    @(negedge clk_i); chk("gnt_adv", imem_addr, 32'h124); chk("gnt_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk_i); chk("outst_limit", {31'b0, imem_req}, 32'd0);
    @(negedge clk_i); chk("slow_wait1", {31'b0, valid}, 32'd0); #2 mem_delay = 0;
    @(negedge clk_i); chk("slow_wait2", {31'b0, valid}, 32'd0);
    @(negedge clk_i); chk_head("slow_a", 32'h120);
    @(negedge clk_i); chk("slow_gap", {31'b0, valid}, 32'd0);
    repeat (2) @(negedge clk_i); chk("slow_gap2", {31'b0, valid}, 32'd0);
    @(negedge clk_i); chk_head("slow_b", 32'h124);
    @(negedge clk_i); chk_head("slow_c", 32'h128);
    @(negedge clk_i); chk_head("slow_d", 32'h12C); #2 mem_delay = 2;

    // Redirect with two responses in flight
    @(negedge clk_i); chk_head("pre_redir", 32'h130);
    @(negedge clk_i);
    chk("redir_empty", {31'b0, valid}, 32'd0);
    chk("redir_out2", {31'b0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h2002; #1;
    chk("redir_noreq", {31'b0, imem_req}, 32'd0);
    #1 mem_delay = 0;
    @(negedge clk_i);
    chk("redir_flush", {31'b0, flush}, 32'd1);
    chk("redir_valid", {31'b0, valid}, 32'd0);
    redirect = 1'b0; #1;
    chk("redir_credit", {31'b0, imem_req}, 32'd0);
    @(negedge clk_i);
    chk("redir_flush_once", {31'b0, flush}, 32'd0);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h2000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("redir_drop", {31'b0, valid}, 32'd0);
    end
    @(negedge clk_i); chk_head("redir_tgt", 32'h2000);
    @(negedge clk_i); chk_head("redir_tgt1", 32'h2004);
    @(negedge clk_i); chk_head("redir_tgt2", 32'h2008);

    // Redirect coinciding with response and pop
    redirect = 1'b1; redirect_pc = 32'h3000;
    @(negedge clk_i);
    chk("redir2_flush", {31'b0, flush}, 32'd1);
    chk("redir2_valid", {31'b0, valid}, 32'd0);
    redirect = 1'b0; #1;
    chk("redir2_req", {31'b0, imem_req}, 32'd1);
    chk("redir2_addr", imem_addr, 32'h3000);
    @(negedge clk_i);
    chk("redir2_flush0", {31'b0, flush}, 32'd0);
    chk("redir2_addr1", imem_addr, 32'h3004);
    @(negedge clk_i); chk_head("redir2_tgt", 32'h3000);
    @(negedge clk_i); chk_head("redir2_tgt1", 32'h3004);

    // Reset with full buffer
    ready = 1'b0; #1;
    chk("full_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk_i);
    chk_head("full_hold", 32'h3004);
    #2 rst_n = 1'b0; #1;
    chk("arst_valid", {31'b0, valid}, 32'd0);
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_flush", {31'b0, flush}, 32'd0);
    @(negedge clk_i); ready = 1'b1;
    @(negedge clk_i); #3 rst_n = 1'b1; #1;
    chk("reboot_req", {31'b0, imem_req}, 32'd1);
    chk("reboot_addr", imem_addr, 32'h100);
    @(negedge clk_i);
    chk("reboot_valid", {31'b0, valid}, 32'd0);
    chk("reboot_addr2", imem_addr, 32'h104);
    @(negedge clk_i); chk_head("reboot_a", 32'h100);
    @(negedge clk_i); chk_head("reboot_b", 32'h104);

    // Reset while the flush pulse is high
    redirect = 1'b1; redirect_pc = 32'h5000;
    @(negedge clk_i);
    chk("flush_pre_rst", {31'b0, flush}, 32'd1);
    redirect = 1'b0;
    #2 rst_n = 1'b0; #1;
    chk("flush_rst", {31'b0, flush}, 32'd0);
    chk("flush_rst_valid", {31'b0, valid}, 32'd0);
    @(negedge clk_i); #3 rst_n = 1'b1; #1;
    chk("reboot2_req", {31'b0, imem_req}, 32'd1);
    chk("reboot2_addr", imem_addr, 32'h100);
    @(negedge clk_i);
    chk("reboot2_addr2", imem_addr, 32'h104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the scalar core, directly upstream of decode. Issues word requests to instruction memory over a req/gnt/rvalid bus, buffers returned instructions with their PCs in a small FIFO, and presents them to decode on a valid/ready handshake. Branch/jump redirects from execute reload the PC, flush the buffer, drop stale in-flight responses and pulse a decode flush.

## Interface
- XLEN, 32, data/address width
- BOOT_ADDR, 32'h0000_0000, PC loaded at reset (bits [1:0] must be 0)
- FIFO_DEPTH, 2, instruction buffer entries; also max outstanding requests (≥2)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  word-aligned fetch address, valid with imem_req_o
- imem_gnt_i  in  1  request accepted when imem_req_o & imem_gnt_i
- imem_rvalid_i  in  1  response valid; in order, one per grant, ≥1 cycle after grant
- imem_rdata_i  in  XLEN  instruction word
- redirect_i  in  1  taken branch/jump/trap redirect
- redirect_pc_i  in  XLEN  new PC; bits [1:0] ignored (treated as 0)
- fetch_instr_valid_o  out  1  buffer head valid
- fetch_pc_r_o  out  XLEN  PC of head instruction
- fetch_instr_o  out  XLEN  head instruction
- fetch_instr_ready_i  in  1  decode accepts head (pop on valid & ready)
- flush_decode_o  out  1  one-cycle registered flush to decode

## Operation
- State: fetch_pc (next issue address), resp_pc (PC of next kept response), FIFO of {pc, instr} with count, outstanding counter (granted, not yet responded), discard counter.
- Issue: imem_req_o = ~redirect_i & (count + outstanding − pop < FIFO_DEPTH), pop = valid & ready this cycle. imem_addr_o = fetch_pc. On grant: fetch_pc += 4 (mod 2^XLEN), outstanding++.
- Response: each imem_rvalid_i decrements outstanding. If discard > 0: discard--, data dropped. Else push {resp_pc, imem_rdata_i}, resp_pc += 4. Credit rule guarantees no push into a full FIFO; push into full is a protocol error (assertion).
- Output: head of FIFO; fetch_instr_valid_o = count ≠ 0. Push and pop same cycle allowed at any occupancy.
- Redirect (cycle R): fetch_pc and resp_pc ← {redirect_pc_i[XLEN-1:2], 2'b00}; FIFO cleared (any pop in R ignored); discard ← outstanding_before_R (rvalid in R is itself dropped and counted against it); no request in R; flush_decode_o = 1 in R+1 only. Back-to-back redirects: last one wins, discard recomputed from current outstanding.
- Reset (async, any time incl. mid-transaction): fetch_pc = resp_pc = BOOT_ADDR, FIFO empty, outstanding = discard = 0, flush_decode_o = 0, fetch_instr_valid_o = 0, imem_req_o = 0 while rst_ni low. Memory side must also be reset; no responses expected after reset.

## Timing
- First imem_req_o in first cycle after rst_ni deasserts, addr BOOT_ADDR.
- Response in cycle N → fetch_instr_valid_o in N+1 (no bypass).
- Single-cycle memory with gnt held high and ready high: one instruction per cycle sustained after 2-cycle start-up.
- Redirect in R → first request to new PC in R+1 → earliest valid instruction R+3 (1-cycle memory).
- fetch_pc_r_o/fetch_instr_o stable while valid & ~ready (no redirect).
- imem_req_o may drop without grant; address may change only after grant or redirect.

## Test plan
- Reset, BOOT_ADDR=0x100, 1-cycle memory returning addr as data, ready=1 -> req at 0x100 cycle 1; valid pcs 0x100,0x104,0x108… one per cycle from cycle 3, instr == pc.
- Ready low 5 cycles mid-stream -> head held stable, exactly FIFO_DEPTH instructions buffered, req low while count+outstanding=2, no instruction lost/duplicated on release.
- gnt low 3 cycles and rvalid delayed 4 cycles -> addr held 0x104 until grant, in-order delivery, outstanding never exceeds 2.
- Redirect to 0x2002 with 2 outstanding -> both responses dropped, FIFO emptied, flush_decode_o single pulse in R+1, next req addr 0x2000, next valid pc 0x2000.
- Redirect coinciding with rvalid and pop -> that response and pop discarded, discard = remaining outstanding, stream resumes at redirect target.
- Assert rst_ni low while 2 requests outstanding and FIFO full -> valid, req, flush immediately 0; after release fetch restarts at BOOT_ADDR.
